// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority / one-hot encoder.
// The index width is computed by idx_width() so every user agrees on W.
package enc_pkg;

  localparam logic ENC_MODE_PRIO   = 1'b0;
  localparam logic ENC_MODE_ONEHOT = 1'b1;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Error flag for the strict one-hot check.
  function automatic logic onehot_check(input logic en, input logic mode, input logic is_one);
    return en && (mode == ENC_MODE_ONEHOT) && !is_one;
  endfunction

endpackage

// File: rtl/enc_prio_core.sv
// Combinational search over req, starting at start and walking downward with wrap.
// It reports the first set index, whether req is empty, and whether exactly one bit is set.
module enc_prio_core
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         none,
  output logic         one
);

  logic [W-1:0] pos;

  // The loop visits the candidate positions from the lowest to the highest priority, so the last hit wins.
  // NOTE: every combinational output is assigned a default first so no latch can be inferred.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    pos  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = start - W'(k);
      if (req[pos]) begin
        idx  = pos;
        none = 1'b0;
      end
    end
  end

  assign one = (req != '0) && ((req & (req - N'(1))) == '0);

endmodule

// File: rtl/encoder_prio_pipe.sv
// One-stage registered N-to-log2(N) encoder with valid/ready on both sides.
// Defining ENCODER_PRIO_PIPE_RR_EN turns priority mode into round-robin.
module encoder_prio_pipe
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_err
);

  typedef struct packed {
    logic [W-1:0] idx;
    logic         none;
    logic         err;
  } result_t;

  localparam result_t RES_IDLE = '{idx: '0, none: 1'b1, err: 1'b0};

  result_t      res_q, res_d;
  logic         fire, out_fire;
  logic [W-1:0] start, core_idx;
  logic         core_none, core_one;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef ENCODER_PRIO_PIPE_RR_EN
  logic [W-1:0] ptr;
  logic         res_prio;

  // The winner of a delivered priority grant becomes the lowest priority for the next search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= W'(N - 1);
      res_prio <= 1'b0;
    end else begin
      if (out_fire && !res_q.none && res_prio) ptr <= res_q.idx - W'(1);
      if (fire) res_prio <= en && (mode == ENC_MODE_PRIO);
    end
  end

  assign start = (mode == ENC_MODE_ONEHOT) ? W'(N - 1) : ptr;
`else
  assign start = W'(N - 1);
`endif

  enc_prio_core #(.N(N)) u_core (
    .req   (req),
    .start (start),
    .idx   (core_idx),
    .none  (core_none),
    .one   (core_one)
  );

  always_comb begin
    res_d = RES_IDLE;
    if (en) begin
      res_d.none = core_none;
      if (mode == ENC_MODE_PRIO) begin
        res_d.idx = core_idx;
      end else begin
        res_d.err = onehot_check(en, mode, core_one);
        if (core_one) res_d.idx = core_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= RES_IDLE;
    end else if (fire) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign out_idx  = res_q.idx;
  assign out_none = res_q.none;
  assign out_err  = res_q.err;

endmodule
